// File: rtl/activation_out_buffer_pkg.sv
// Shared types and default sizing for the activation output buffer.
package ita_package;

  localparam int N             = 16;
  localparam int ACT_LANE_W    = 8;
  localparam int ACT_BUF_DEPTH = 4;
  localparam int ACT_LATENCY   = 2;

  typedef logic signed [ACT_LANE_W-1:0] requant_lane_t;
  typedef requant_lane_t [N-1:0]        requant_oup_t;

endpackage

// File: rtl/activation_out_buffer_fifo.sv
// Generic DEPTH x W register FIFO with explicit occupancy count, modulo-DEPTH
// pointers (any DEPTH), sticky overflow on a lost push, async active-high reset.
module act_buf_fifo
  import ita_package::*;
#(
  parameter int DEPTH = ACT_BUF_DEPTH,
  parameter int W     = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             empty, full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    do_pop  = pop_i & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push_i & (~full | do_pop);

    mem_d = mem_q;
    if (do_push) mem_d[wptr_q] = data_i;

    wptr_d = do_push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = do_pop  ? ptr_inc(rptr_q) : rptr_q;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q | (push_i & ~do_push);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q      <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = mem_q[rptr_q];
  assign valid_o    = ~empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/activation_out_buffer.sv
// Captures activation results LATENCY cycles after calc_en_i into a FIFO with
// early stall. Define ITA_ACT_BUF_LAST_EN to carry a tile-last flag (last_i/last_o).
module activation_out_buffer
  import ita_package::*;
#(
  parameter int N_PE    = N,
  parameter int WIDTH   = $bits(requant_lane_t),
  parameter int DEPTH   = ACT_BUF_DEPTH,
  parameter int LATENCY = ACT_LATENCY,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  calc_en_i,
  input  logic [N_PE*WIDTH-1:0] data_i,
  output logic                  stall_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [N_PE*WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]      count_o,
`ifdef ITA_ACT_BUF_LAST_EN
  input  logic                  last_i,
  output logic                  last_o,
`endif
  output logic                  overflow_o
);

  localparam int DATA_BITS = N_PE * WIDTH;
`ifdef ITA_ACT_BUF_LAST_EN
  localparam int ENTRY_W = DATA_BITS + 1;
`else
  localparam int ENTRY_W = DATA_BITS;
`endif
  localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] en_q, en_d;
  logic               push, pop, fifo_valid;
  logic [CNT_W-1:0]   count;
  logic [SUM_W-1:0]   inflight, occupancy;
  logic [ENTRY_W-1:0] entry_in, entry_out;

  always_comb begin
    en_d    = en_q;
    en_d[0] = calc_en_i;
    for (int i = 1; i < LATENCY; i++) en_d[i] = en_q[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) en_q <= '0;
    else       en_q <= en_d;
  end

`ifdef ITA_ACT_BUF_LAST_EN
  logic [LATENCY-1:0] last_q, last_d;

  always_comb begin
    last_d    = last_q;
    last_d[0] = last_i;
    for (int i = 1; i < LATENCY; i++) last_d[i] = last_q[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= '0;
    else       last_q <= last_d;
  end

  assign entry_in = {last_q[LATENCY-1], data_i};
  assign last_o   = fifo_valid & entry_out[ENTRY_W-1];
`else
  assign entry_in = data_i;
`endif

  assign push = en_q[LATENCY-1];
  assign pop  = fifo_valid & ready_i;

  // Reserve a slot for every beat still inside activation; ignoring a
  // same-cycle pop keeps ready_i out of the stall path.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SUM_W'(en_q[i]);
    occupancy = SUM_W'(count) + inflight;
    stall_o   = (occupancy >= SUM_W'(DEPTH));
  end

  act_buf_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .pop_i      (pop),
    .data_i     (entry_in),
    .data_o     (entry_out),
    .valid_o    (fifo_valid),
    .count_o    (count),
    .overflow_o (overflow_o)
  );

  assign valid_o = fifo_valid;
  assign data_o  = entry_out[DATA_BITS-1:0];
  assign count_o = count;

endmodule

// File: tb/tb_activation_out_buffer.sv
// Randomized bench for activation_out_buffer against a queue-based reference model.
module tb_activation_out_buffer;
  import ita_package::*;

  localparam int N_PE    = 16;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;
  localparam int DW      = N_PE * WIDTH;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             calc_en = 1'b0;
  logic             ready   = 1'b0;
  logic             last_in = 1'b0;
  logic [DW-1:0]    din     = '0;
  logic             stall, valid, ovf;
  logic [DW-1:0]    dout;
  logic [CNT_W-1:0] count;
`ifdef ITA_ACT_BUF_LAST_EN
  logic             last_out;
`endif

  always #5 clk = ~clk;

  activation_out_buffer #(
    .N_PE(N_PE), .WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .calc_en_i  (calc_en),
    .data_i     (din),
    .stall_o    (stall),
    .valid_o    (valid),
    .ready_i    (ready),
    .data_o     (dout),
    .count_o    (count),
`ifdef ITA_ACT_BUF_LAST_EN
    .last_i     (last_in),
    .last_o     (last_out),
`endif
    .overflow_o (ovf)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: enables are remembered by the cycle they were issued and
  // land in the FIFO queue exactly LATENCY cycles later.
  logic [DW-1:0] mq[$];
  bit            ml[$];
  int            pend_cyc[$];
  bit            pend_last[$];
  bit            m_ovf;
  int            cyc;

  always @(posedge clk or posedge rst) begin : model
    bit push, pop, was_full, lst;
    if (rst) begin
      mq.delete(); ml.delete(); pend_cyc.delete(); pend_last.delete();
      m_ovf = 1'b0;
      cyc   = 0;
    end else begin
      lst      = 1'b0;
      push     = (pend_cyc.size() > 0) && (pend_cyc[0] == cyc - LATENCY);
      pop      = (mq.size() > 0) && ready;
      was_full = (mq.size() == DEPTH);
      if (push) begin
        void'(pend_cyc.pop_front());
        lst = pend_last.pop_front();
      end
      if (calc_en) begin
        pend_cyc.push_back(cyc);
        pend_last.push_back(last_in);
      end
      if (pop) begin
        void'(mq.pop_front());
        void'(ml.pop_front());
      end
      if (push) begin
        if (!was_full || pop) begin
          mq.push_back(din);
          ml.push_back(lst);
        end else begin
          m_ovf = 1'b1;
        end
      end
      cyc++;
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      chk("valid_o", DW'(valid), DW'(mq.size() > 0));
      chk("count_o", DW'(count), DW'(mq.size()));
      chk("stall_o", DW'(stall), DW'((mq.size() + pend_cyc.size()) >= DEPTH));
      chk("overflow_o", DW'(ovf), DW'(m_ovf));
      if (mq.size() > 0) chk("data_o", dout, mq[0]);
`ifdef ITA_ACT_BUF_LAST_EN
      chk("last_o", DW'(last_out), DW'((mq.size() > 0) && ml[0]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, first_pop, last_pop;
    bit saw_stall;

    // Reset
    rst = 1'b1;
    repeat (10) tick();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_valid", DW'(valid), '0);
    chk("rst_stall", DW'(stall), '0);
    chk("rst_count", DW'(count), '0);
    chk("rst_ovf", DW'(ovf), '0);
    chk("rst_data", dout, '0);

    // Single beat: enable in cycle 0, result data presented in cycle 2
    ready = 1'b1; calc_en = 1'b1; din = rnd();
    tick();
    calc_en = 1'b0; din = rnd();
    tick();
    for (int i = 0; i < N_PE; i++) din[i*WIDTH +: WIDTH] = 8'(i - 8);
    tick();
    din = rnd();
    chk("single_valid", DW'(valid), DW'(1));
    chk("single_data", dout, 128'h0706050403020100FFFEFDFCFBFAF9F8);
    chk("single_count", DW'(count), DW'(1));
    tick();
    chk("single_drained", DW'(count), '0);

    // Streaming: 64 back-to-back beats
    pops = 0; first_pop = -1; last_pop = -1;
    for (int b = 0; b < 64 + LATENCY + 4; b++) begin
      calc_en = (b < 64);
      last_in = (b == 63);
      din     = rnd();
      chk("stream_no_stall", DW'(stall), '0);
      if (valid) begin
        if (first_pop < 0) first_pop = b;
        last_pop = b;
        pops++;
      end
      tick();
    end
    calc_en = 1'b0; last_in = 1'b0;
    chk("stream_beats", DW'(pops), DW'(64));
    chk("stream_b2b", DW'(last_pop - first_pop), DW'(63));

    // Backpressure with a compliant producer
    ready = 1'b0; saw_stall = 1'b0;
    for (int b = 0; b < 12; b++) begin
      calc_en = !stall;
      din     = rnd();
      if (stall) saw_stall = 1'b1;
      tick();
    end
    calc_en = 1'b0;
    repeat (3) tick();
    chk("bp_count", DW'(count), DW'(DEPTH));
    chk("bp_ovf", DW'(ovf), '0);
    chk("bp_saw_stall", DW'(saw_stall), DW'(1));
    ready = 1'b1;
    repeat (6) tick();
    chk("bp_drained", DW'(count), '0);

    // Forced overflow: 6 beats while stalled and blocked
    ready = 1'b0;
    for (int b = 0; b < 6; b++) begin
      calc_en = 1'b1; din = rnd();
      tick();
    end
    calc_en = 1'b0;
    repeat (4) tick();
    chk("ovf_flag", DW'(ovf), DW'(1));
    chk("ovf_count", DW'(count), DW'(DEPTH));
    ready = 1'b1;
    repeat (6) tick();
    ready = 1'b0;
    chk("ovf_sticky", DW'(ovf), DW'(1));
    chk("ovf_drained", DW'(count), '0);

    // Full FIFO with a push and a pop in the same cycle
    for (int b = 0; b < DEPTH; b++) begin
      calc_en = 1'b1; din = rnd();
      tick();
    end
    calc_en = 1'b0;
    repeat (3) tick();
    chk("full_count", DW'(count), DW'(DEPTH));
    calc_en = 1'b1; din = rnd();
    tick();
    calc_en = 1'b0; din = rnd();
    tick();
    ready = 1'b1; din = rnd();
    tick();
    ready = 1'b0;
    chk("full_pushpop_count", DW'(count), DW'(DEPTH));
    ready = 1'b1;
    repeat (3) tick();
    calc_en = 1'b1; din = rnd();
    repeat (2) tick();

    // Asynchronous reset mid-stream
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", DW'(valid), '0);
    chk("arst_count", DW'(count), '0);
    chk("arst_stall", DW'(stall), '0);
    chk("arst_ovf", DW'(ovf), '0);
    chk("arst_data", dout, '0);
    calc_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (LATENCY + 1) tick();
    chk("arst_no_ghost", DW'(count), '0);

    // Random traffic with a compliant producer
    for (int b = 0; b < 400; b++) begin
      ready   = ($urandom_range(0, 3) != 0);
      calc_en = !stall && ($urandom_range(0, 1) == 1);
      last_in = ($urandom_range(0, 7) == 0);
      din     = rnd();
      tick();
    end
    calc_en = 1'b0; ready = 1'b1;
    repeat (8) tick();
    chk("rand_drained", DW'(count), '0);
    chk("rand_no_ovf", DW'(ovf), '0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
